pwm_channel_gen: RTL and testbench
==================================

PWM_CHANNEL_GEN -- requirements
Module: pwm_channel_gen

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 13, system clocks per PWM counter step; legal range 1..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port en_reg_out_7_0, input, 8 bits: output-enable bits for channels 7..0.
REQ-005 The block SHALL have port en_reg_out_15_8, input, 8 bits: output-enable bits for channels 15..8.
REQ-006 The block SHALL have port en_reg_pwm_7_0, input, 8 bits: PWM-mode bits for channels 7..0.
REQ-007 The block SHALL have port en_reg_pwm_15_8, input, 8 bits: PWM-mode bits for channels 15..8.
REQ-008 The block SHALL have port pwm_duty_cycle, input, 8 bits: requested duty, shared by all channels.
REQ-009 The block SHALL have port out, output, 16 bits, registered: channel drive levels, bit i = channel i.
REQ-010 The block SHALL have port period_strobe, output, 1 bit, registered: one-cycle pulse at each PWM period start.

Function
REQ-011 The block SHALL treat all configuration inputs as synchronous to clk, held stable by the upstream register bank; no resynchronisation.
REQ-012 Prescaler presc_cnt (16 bits) SHALL count 0..PRESCALE-1 and wrap to 0; tick is asserted in the cycle presc_cnt == PRESCALE-1.
REQ-013 With PRESCALE = 1, tick SHALL be asserted every cycle.
REQ-014 8-bit pwm_cnt SHALL increment on tick only, wrapping 255 -> 0; period = 256*PRESCALE clocks (3328 at default).
REQ-015 Wrap event = tick while pwm_cnt == 255; on it duty_shadow SHALL load pwm_duty_cycle.
REQ-016 pwm_duty_cycle changes between wrap events SHALL NOT affect the current period (glitch-free duty update).
REQ-017 pwm_level SHALL be 1 when duty_shadow == 255, else (pwm_cnt < duty_shadow); duty 0 -> constant 0, 255 -> constant 1.
REQ-018 Per channel i the next out[i] SHALL be: 0 if en_out[i] = 0; 1 if en_out[i] = 1 and en_pwm[i] = 0; pwm_level if both are 1.
REQ-019 out SHALL be registered: out reflects the enable inputs and pwm_cnt/duty_shadow of the previous cycle (1-cycle latency).
REQ-020 Enable-bit changes SHALL take effect on out one cycle later, regardless of PWM phase.
REQ-021 period_strobe SHALL be 1 for exactly the cycle after each wrap event, else 0.
REQ-022 High time per period for duty D (0 < D < 255) SHALL be D*PRESCALE clocks, contiguous, starting at the period start.
REQ-023 All channels in PWM mode SHALL switch on the same cycle (common counter; no per-channel phase).

Reset
REQ-024 While rst_n = 0: presc_cnt = 0, pwm_cnt = 0, duty_shadow = 0, out = 16'h0000, period_strobe = 0.
REQ-025 Reset assertion SHALL clear state immediately (asynchronous); release mid-period SHALL start a fresh period from count 0.
REQ-026 After reset release, PWM channels SHALL stay low until the first wrap event loads duty_shadow (256*PRESCALE clocks).

Verification
REQ-027 PRESCALE=13, en_out=16'hFFFF, en_pwm=16'hFFFF, duty=128, after first wrap -> every out bit high 1664 clks, low 1664 clks, period 3328; period_strobe spaced 3328.
REQ-028 en_out=16'h00FF, en_pwm=16'h0000 -> out = 16'h00FF static one cycle after the change; duty ignored.
REQ-029 duty=0 then duty=255 (PWM mode, all enabled) -> out constant 0 for a full period, then constant 16'hFFFF from the next period start, no glitch pulses.
REQ-030 duty changed 64 -> 192 at pwm_cnt = 100 -> current period keeps 64*13 clk high time; the next period shows 192*13.
REQ-031 rst_n pulsed low at pwm_cnt = 150 -> out = 0 asynchronously; after release, pwm_cnt restarts at 0, first strobe 3328 clks later.
REQ-032 PRESCALE=1, duty=1 -> out high exactly 1 clock per 256-clock period.

Source files
------------

// File: rtl/pwm_channel_gen.sv
// -----------------------------------------------------------------------------
// pwm_channel_gen
//   Sixteen-channel output driver. All channels share one PWM generator:
//   a prescaler feeds an 8-bit period counter. The duty is captured into a
//   shadow register only at the period wrap, so the waveform never glitches
//   when the duty input changes. Each channel is forced low, forced high or
//   follows the shared PWM level, selected by its enable bits.
//
// Ports
//   clk              system clock, all state updates on the rising edge
//   rst_n            asynchronous active-low reset
//   en_reg_out_7_0   output-enable bits, channels 7..0
//   en_reg_out_15_8  output-enable bits, channels 15..8
//   en_reg_pwm_7_0   PWM-mode bits, channels 7..0
//   en_reg_pwm_15_8  PWM-mode bits, channels 15..8
//   pwm_duty_cycle   requested duty (0 = always low, 255 = always high)
//   out              registered channel levels, bit i = channel i
//   period_strobe    registered one-cycle pulse at the start of each period
// -----------------------------------------------------------------------------
module pwm_channel_gen #(
   parameter int unsigned PRESCALE = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_strobe
);

   localparam int unsigned PRESC_W = 16;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned NCH     = 16;

   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

   logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
   logic [CNT_W-1:0]   pwm_cnt_q, pwm_cnt_d;
   logic [CNT_W-1:0]   duty_shadow_q, duty_shadow_d;
   logic [NCH-1:0]     out_q, out_d;
   logic               strobe_q, strobe_d;

   logic               tick_c;
   logic               wrap_c;
   logic               pwm_level_c;
   logic [NCH-1:0]     en_out_c;
   logic [NCH-1:0]     en_pwm_c;

   assign en_out_c = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm_c = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   // Counter events: tick advances the PWM counter, wrap closes the period.
   assign tick_c = (presc_cnt_q == PRESC_MAX);
   assign wrap_c = tick_c && (pwm_cnt_q == CNT_MAX);

   // Duty 255 is treated as fully on, otherwise the count 255 slot would be low.
   assign pwm_level_c = (duty_shadow_q == CNT_MAX) || (pwm_cnt_q < duty_shadow_q);

   // Next-state logic for counters, duty shadow and outputs.
   always_comb begin
      presc_cnt_d   = presc_cnt_q;
      pwm_cnt_d     = pwm_cnt_q;
      duty_shadow_d = duty_shadow_q;
      out_d         = '0;
      strobe_d      = 1'b0;

      if (tick_c) begin
         presc_cnt_d = '0;
         pwm_cnt_d   = pwm_cnt_q + CNT_W'(1);
      end else begin
         presc_cnt_d = presc_cnt_q + PRESC_W'(1);
      end

      // Duty is only sampled at the period boundary.
      if (wrap_c) begin
         duty_shadow_d = pwm_duty_cycle;
      end

      // Disabled -> 0, static mode -> 1, PWM mode -> shared level.
      out_d    = en_out_c & (~en_pwm_c | {NCH{pwm_level_c}});
      strobe_d = wrap_c;
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_cnt_q   <= '0;
         pwm_cnt_q     <= '0;
         duty_shadow_q <= '0;
         out_q         <= '0;
         strobe_q      <= 1'b0;
      end else begin
         presc_cnt_q   <= presc_cnt_d;
         pwm_cnt_q     <= pwm_cnt_d;
         duty_shadow_q <= duty_shadow_d;
         out_q         <= out_d;
         strobe_q      <= strobe_d;
      end
   end

   assign out           = out_q;
   assign period_strobe = strobe_q;

endmodule

// File: tb/tb_pwm_channel_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_channel_gen
//   Drives two instances (PRESCALE 13 and 1) from shared configuration inputs.
//   A cycle-count reference model derives the expected outputs from elapsed
//   clocks since reset; scenario tasks add direct high-time / spacing checks.
// -----------------------------------------------------------------------------
module tb_pwm_channel_gen;

   localparam int PER13 = 256 * 13;
   localparam int PER1  = 256;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  eo_lo = 8'h00, eo_hi = 8'h00, ep_lo = 8'h00, ep_hi = 8'h00;
   logic [7:0]  duty  = 8'h00;
   logic [15:0] out13, out1;
   logic        str13, str1;
   logic [15:0] en_out, en_pwm;

   int errors = 0;
   int checks = 0;

   assign en_out = {eo_hi, eo_lo};
   assign en_pwm = {ep_hi, ep_lo};

   pwm_channel_gen #(.PRESCALE(13)) dut13 (
      .clk(clk), .rst_n(rst_n),
      .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
      .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
      .pwm_duty_cycle(duty), .out(out13), .period_strobe(str13));

   pwm_channel_gen #(.PRESCALE(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
      .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
      .pwm_duty_cycle(duty), .out(out1), .period_strobe(str1));

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Expected outputs from elapsed clocks n since reset release:
   // step = n / PRESCALE, count = step mod 256, period ends every 256*PRESCALE clocks.
   function automatic logic [15:0] model_out(input logic [15:0] eo, input logic [15:0] ep,
                                             input int cnt, input logic [7:0] sh);
      logic lvl;
      lvl = (sh == 8'd255) || (cnt < int'(sh));
      return (eo & ~ep) | (eo & ep & {16{lvl}});
   endfunction

   int          n13, n1;
   logic [7:0]  sh13, sh1;
   logic [15:0] mo13, mo1;
   logic        ms13, ms1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n13 <= 0; sh13 <= 8'h00; mo13 <= 16'h0; ms13 <= 1'b0;
      end else begin
         mo13 <= model_out(en_out, en_pwm, (n13 / 13) % 256, sh13);
         ms13 <= ((n13 % PER13) == PER13 - 1);
         if ((n13 % PER13) == PER13 - 1) sh13 <= duty;
         n13 <= n13 + 1;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n1 <= 0; sh1 <= 8'h00; mo1 <= 16'h0; ms1 <= 1'b0;
      end else begin
         mo1 <= model_out(en_out, en_pwm, n1 % 256, sh1);
         ms1 <= ((n1 % PER1) == PER1 - 1);
         if ((n1 % PER1) == PER1 - 1) sh1 <= duty;
         n1 <= n1 + 1;
      end
   end

   // Bounded wait for the next period_strobe of the PRESCALE=13 instance.
   task automatic wait_strobe13(input int limit, output int cyc, output bit found);
      cyc = 0; found = 1'b0;
      while (!found && cyc < limit) begin
         @(negedge clk);
         cyc++;
         if (str13) found = 1'b1;
      end
   endtask

   task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
      eo_lo = eo[7:0]; eo_hi = eo[15:8];
      ep_lo = ep[7:0]; ep_hi = ep[15:8];
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int c; bit f; int nz;
      set_en(16'hFFFF, 16'hFFFF);
      duty = 8'd128;
      repeat (3) @(negedge clk);
      checks++; if (out13 !== 16'h0) begin errors++; $display("FAIL reset_out13: got %h want 0000", out13); end
      checks++; if (str13 !== 1'b0)  begin errors++; $display("FAIL reset_strobe13: got %b want 0", str13); end
      checks++; if (out1 !== 16'h0)  begin errors++; $display("FAIL reset_out1: got %h want 0000", out1); end
      #2 rst_n = 1'b1;
      nz = 0; c = 0; f = 1'b0;
      while (!f && c < PER13 + 10) begin
         @(negedge clk);
         c++;
         if (str13) f = 1'b1;
         else if (out13 !== 16'h0) nz++;
      end
      checks++; if (!f || c != PER13) begin errors++; $display("FAIL first_strobe: got %0d clks (found=%0d) want %0d", c, f, PER13); end
      checks++; if (nz != 0) begin errors++; $display("FAIL low_until_wrap: got %0d nonzero cycles want 0", nz); end
   endtask

   // Entered on a strobe cycle with duty 128 loaded.
   task automatic test_duty128();
      int high, mixed, rises, nstr, first_str, mism;
      logic prev;
      high = 0; mixed = 0; rises = 0; nstr = 0; first_str = 0; mism = 0; prev = out13[0];
      for (int i = 1; i <= PER13; i++) begin
         @(negedge clk);
         if (out13 === 16'hFFFF) high++;
         else if (out13 !== 16'h0) mixed++;
         if (out13[0] && !prev) rises++;
         prev = out13[0];
         if (str13) begin nstr++; if (first_str == 0) first_str = i; end
         if (out13 !== mo13 || str13 !== ms13) mism++;
      end
      checks++; if (high != 1664)      begin errors++; $display("FAIL d128_high: got %0d want 1664", high); end
      checks++; if (PER13 - high - mixed != 1664) begin errors++; $display("FAIL d128_low: got %0d want 1664", PER13 - high - mixed); end
      checks++; if (mixed != 0)        begin errors++; $display("FAIL d128_common_phase: got %0d split cycles want 0", mixed); end
      checks++; if (rises != 1)        begin errors++; $display("FAIL d128_contiguous: got %0d rises want 1", rises); end
      checks++; if (nstr != 1 || first_str != PER13) begin errors++; $display("FAIL d128_strobe: got %0d strobes at %0d want 1 at %0d", nstr, first_str, PER13); end
      checks++; if (mism != 0)         begin errors++; $display("FAIL d128_model: got %0d mismatches want 0", mism); end
   endtask

   task automatic test_duty_change();
      int c, high; bit f;
      duty = 8'd64;
      wait_strobe13(PER13 + 10, c, f);
      checks++; if (!f) begin errors++; $display("FAIL dchg_wait: no strobe within %0d clks", c); end
      high = 0;
      for (int i = 1; i <= PER13; i++) begin
         @(negedge clk);
         if (i == 100 * 13) duty = 8'd192;
         if (out13[0]) high++;
      end
      checks++; if (high != 64 * 13)  begin errors++; $display("FAIL dchg_cur_period: got %0d want %0d", high, 64 * 13); end
      checks++; if (str13 !== 1'b1)   begin errors++; $display("FAIL dchg_strobe: got %b want 1", str13); end
      high = 0;
      for (int i = 1; i <= PER13; i++) begin
         @(negedge clk);
         if (out13[0]) high++;
      end
      checks++; if (high != 192 * 13) begin errors++; $display("FAIL dchg_next_period: got %0d want %0d", high, 192 * 13); end
   endtask

   // Entered on a strobe cycle.
   task automatic test_duty_extremes();
      int c, nz, full; bit f;
      duty = 8'd0;
      wait_strobe13(PER13 + 10, c, f);
      checks++; if (!f) begin errors++; $display("FAIL dext_wait: no strobe within %0d clks", c); end
      duty = 8'd255;
      nz = 0;
      for (int i = 1; i <= PER13; i++) begin
         @(negedge clk);
         if (out13 !== 16'h0) nz++;
      end
      checks++; if (nz != 0)         begin errors++; $display("FAIL duty0_const: got %0d nonzero cycles want 0", nz); end
      checks++; if (str13 !== 1'b1)  begin errors++; $display("FAIL dext_strobe: got %b want 1", str13); end
      full = 0;
      for (int i = 1; i <= PER13; i++) begin
         @(negedge clk);
         if (out13 === 16'hFFFF) full++;
      end
      checks++; if (full != PER13)   begin errors++; $display("FAIL duty255_const: got %0d full cycles want %0d", full, PER13); end
   endtask

   task automatic test_static();
      int bad;
      @(negedge clk);
      set_en(16'h00FF, 16'h0000);
      duty = 8'd37;
      @(negedge clk);
      checks++; if (out13 !== 16'h00FF) begin errors++; $display("FAIL static_latency: got %h want 00ff", out13); end
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 10) duty = 8'd200;
         if (out13 !== 16'h00FF || out1 !== 16'h00FF) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL static_hold: got %0d bad cycles want 0", bad); end
   endtask

   task automatic test_reset_mid();
      int c, nz; bit f;
      set_en(16'hFFFF, 16'hFFFF);
      duty = 8'd200;
      wait_strobe13(PER13 + 10, c, f);
      checks++; if (!f) begin errors++; $display("FAIL rmid_wait: no strobe within %0d clks", c); end
      repeat (150 * 13) @(negedge clk);
      checks++; if (out13 !== 16'hFFFF) begin errors++; $display("FAIL rmid_pre: got %h want ffff", out13); end
      #3 rst_n = 1'b0;
      #1;
      checks++; if (out13 !== 16'h0 || out1 !== 16'h0) begin errors++; $display("FAIL rmid_async: got %h/%h want 0000", out13, out1); end
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      c = 0; f = 1'b0; nz = 0;
      while (!f && c < PER13 + 10) begin
         @(negedge clk);
         c++;
         if (str13) f = 1'b1;
         else if (out13 !== 16'h0) nz++;
      end
      checks++; if (!f || c != PER13) begin errors++; $display("FAIL rmid_restart: got %0d clks (found=%0d) want %0d", c, f, PER13); end
      checks++; if (nz != 0) begin errors++; $display("FAIL rmid_low: got %0d nonzero cycles want 0", nz); end
   endtask

   task automatic test_prescale1();
      int c, nstr, high, first_str, mism;
      set_en(16'hFFFF, 16'hFFFF);
      duty = 8'd1;
      nstr = 0; c = 0;
      while (nstr < 2 && c < 3 * PER1) begin
         @(negedge clk);
         c++;
         if (str1) nstr++;
      end
      checks++; if (nstr != 2) begin errors++; $display("FAIL p1_wait: got %0d strobes want 2", nstr); end
      high = 0; nstr = 0; first_str = 0; mism = 0;
      for (int i = 1; i <= PER1; i++) begin
         @(negedge clk);
         if (out1[0]) high++;
         if (str1) begin nstr++; if (first_str == 0) first_str = i; end
         if (out1 !== mo1 || str1 !== ms1) mism++;
      end
      checks++; if (high != 1) begin errors++; $display("FAIL p1_high: got %0d want 1", high); end
      checks++; if (nstr != 1 || first_str != PER1) begin errors++; $display("FAIL p1_period: got %0d strobes at %0d want 1 at %0d", nstr, first_str, PER1); end
      checks++; if (mism != 0) begin errors++; $display("FAIL p1_model: got %0d mismatches want 0", mism); end
   endtask

   task automatic test_random();
      int m13, m1;
      m13 = 0; m1 = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (out13 !== mo13 || str13 !== ms13) begin
            if (m13 == 0) $display("FAIL rand13 cycle %0d: got %h/%b want %h/%b", i, out13, str13, mo13, ms13);
            m13++;
         end
         if (out1 !== mo1 || str1 !== ms1) begin
            if (m1 == 0) $display("FAIL rand1 cycle %0d: got %h/%b want %h/%b", i, out1, str1, mo1, ms1);
            m1++;
         end
         if ($urandom_range(49, 0) == 0) set_en(16'($urandom), 16'($urandom));
         if ($urandom_range(199, 0) == 0) duty = 8'($urandom);
      end
      checks++; if (m13 != 0) begin errors++; $display("FAIL rand13_total: got %0d mismatches want 0", m13); end
      checks++; if (m1 != 0)  begin errors++; $display("FAIL rand1_total: got %0d mismatches want 0", m1); end
   endtask

   initial begin
      test_reset();
      test_duty128();
      test_duty_change();
      test_duty_extremes();
      test_static();
      test_reset_mid();
      test_prescale1();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors + 1, checks);
      $fatal(1, "watchdog");
   end

endmodule
